// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
//   SEG_0 .. SEG_F : active-low glyphs, bit order {a,b,c,d,e,f,g}
//   SEG_BLANK      : all segments off
//   AN_OFF         : level that switches a single anode off (active-low anodes)
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       AN_OFF    = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder.
//   nibble : 4-bit digit value
//   hex_en : 1 = values 10..15 render as A..F, 0 = they are invalid
//   segs   : active-low segments {a,b,c,d,e,f,g}; SEG_BLANK when invalid
//   valid  : 0 when the nibble has no glyph (10..15 with hex_en low)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] segs,
    output logic       valid
);

    always_comb begin
        segs  = SEG_BLANK;
        valid = 1'b1;
        case (nibble)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = SEG_A;
            4'hB: segs = SEG_B;
            4'hC: segs = SEG_C;
            4'hD: segs = SEG_D;
            4'hE: segs = SEG_E;
            4'hF: segs = SEG_F;
            default: segs = SEG_BLANK;
        endcase
        // Non-decimal values are only displayable in hex mode.
        if ((nibble > 4'd9) && !hex_en) begin
            segs  = SEG_BLANK;
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment display driver.
// A packed digit word is captured into a pending register on load and moved
// into the displayed (shadow) copy only when the scan wraps to digit 0, so a
// frame never shows a mix of old and new digits.
//   clk        : system clock
//   reset      : synchronous, active-high
//   load       : capture bcd_in/dp_in/blank_in this cycle
//   bcd_in     : digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   dp_in      : per-digit decimal point request (1 = lit)
//   blank_in   : per-digit force-dark request
//   seg, dp    : active-low shared cathodes, seg[6]=a .. seg[0]=g
//   an         : active-low anodes, at most one low
//   frame_done : one-cycle pulse when the scan index wraps to 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1,
    parameter int HEX_EN        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          HEX_ON     = (HEX_EN != 0);

    // Scan timing
    logic [PW-1:0] presc_reg, presc_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          tick;
    logic          wrap;

    // Pending (last load) and shadow (displayed) copies
    logic [4*NUM_DIGITS-1:0] pend_bcd_reg, pend_bcd_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic [NUM_DIGITS-1:0]   pend_blank_reg, pend_blank_next;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_reg, shadow_bcd_next;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
    logic [NUM_DIGITS-1:0]   shadow_blank_reg, shadow_blank_next;

    // Output registers
    logic [6:0]            seg_reg, seg_next;
    logic                  dp_reg, dp_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_done_reg, frame_done_next;

    // Per-digit decode results
    logic [6:0]            dig_segs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_valid;
    logic [NUM_DIGITS-1:0] zero_upto;   // digits NUM_DIGITS-1..i all zero
    logic [NUM_DIGITS-1:0] dig_dark;

    assign tick = (presc_reg == PRESC_LAST);
    assign wrap = tick && (idx_reg == IDX_LAST);

    // ------------------------------------------------------------------
    // Per-digit decode and leading-zero suppression chain
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam bit SUPPRESS = (BLANK_LEADING != 0) && (gi > 0);
            logic [3:0] nib;

            assign nib = shadow_bcd_reg[4*gi +: 4];

            seg7_decode u_decode (
                .nibble (nib),
                .hex_en (HEX_ON),
                .segs   (dig_segs[gi]),
                .valid  (dig_valid[gi])
            );

            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_upto[gi] = (nib == 4'd0);
            end else begin : g_chain
                assign zero_upto[gi] = (nib == 4'd0) && zero_upto[gi+1];
            end

            // Digit 0 is never suppressed, so "0" still shows for a zero value.
            assign dig_dark[gi] = shadow_blank_reg[gi] | ~dig_valid[gi]
                                | (SUPPRESS & zero_upto[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        presc_next = tick ? '0 : presc_reg + PW'(1);
        idx_next   = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
    end

    always_comb begin
        pend_bcd_next     = pend_bcd_reg;
        pend_dp_next      = pend_dp_reg;
        pend_blank_next   = pend_blank_reg;
        shadow_bcd_next   = shadow_bcd_reg;
        shadow_dp_next    = shadow_dp_reg;
        shadow_blank_next = shadow_blank_reg;
        if (load) begin
            pend_bcd_next   = bcd_in;
            pend_dp_next    = dp_in;
            pend_blank_next = blank_in;
        end
        // A load on the wrap cycle bypasses pending so it is not a frame late.
        if (wrap) begin
            shadow_bcd_next   = load ? bcd_in   : pend_bcd_reg;
            shadow_dp_next    = load ? dp_in    : pend_dp_reg;
            shadow_blank_next = load ? blank_in : pend_blank_reg;
        end
    end

    always_comb begin
        seg_next        = SEG_BLANK;
        dp_next         = 1'b1;
        an_next         = {NUM_DIGITS{AN_OFF}};
        frame_done_next = wrap;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx_reg == IW'(i)) && !dig_dark[i]) begin
                seg_next   = dig_segs[i];
                dp_next    = ~shadow_dp_reg[i];
                an_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg        <= '0;
            idx_reg          <= '0;
            pend_bcd_reg     <= '0;
            pend_dp_reg      <= '0;
            pend_blank_reg   <= '0;
            shadow_bcd_reg   <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            seg_reg          <= SEG_BLANK;
            dp_reg           <= 1'b1;
            an_reg           <= {NUM_DIGITS{AN_OFF}};
            frame_done_reg   <= 1'b0;
        end else begin
            presc_reg        <= presc_next;
            idx_reg          <= idx_next;
            pend_bcd_reg     <= pend_bcd_next;
            pend_dp_reg      <= pend_dp_next;
            pend_blank_reg   <= pend_blank_next;
            shadow_bcd_reg   <= shadow_bcd_next;
            shadow_dp_reg    <= shadow_dp_next;
            shadow_blank_reg <= shadow_blank_next;
            seg_reg          <= seg_next;
            dp_reg           <= dp_next;
            an_reg           <= an_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, REFRESH_DIV=4).
// Two instances share the stimulus: one decimal-only, one with hex glyphs.
// Each clock the stimulus pushes the expected outputs of both instances;
// the monitor pops one entry per clock and compares.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;

    logic [6:0]  seg, seg_h;
    logic        dp, dp_h;
    logic [3:0]  an, an_h;
    logic        fd, fd_h;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1), .HEX_EN(0)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(fd)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1), .HEX_EN(1)
    ) dut_hex (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [3:0] an_h;
        logic [6:0] seg_h;
        logic       dp_h;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   mon_cyc = 0;
    bit   stim_done = 0;

    localparam exp_t RST = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0,
                             an_h: 4'hF, seg_h: 7'h7F, dp_h: 1'b1};

    function automatic logic [3:0] an_of(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Hand-computed display content per frame (f) and digit slot (d).
    //  f0/f3: 0000       f1: 1234 dp on digit2   f2: 0050
    //  f4: 00A0          f5: 9999                f6/f7: 5678 dp digit0, digit2 blanked
    function automatic exp_t slot(input int f, input int d, input logic fd_bit);
        exp_t e;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = fd_bit;
        case (f)
            0, 3, 4: begin
                if (d == 0) begin e.an = 4'b1110; e.seg = 7'b0000001; end
            end
            1: begin
                e.an = an_of(d);
                case (d)
                    0: e.seg = 7'b1001100;
                    1: e.seg = 7'b0000110;
                    2: begin e.seg = 7'b0010010; e.dp = 1'b0; end
                    default: e.seg = 7'b1001111;
                endcase
            end
            2: begin
                if (d == 0) begin e.an = 4'b1110; e.seg = 7'b0000001; end
                if (d == 1) begin e.an = 4'b1101; e.seg = 7'b0100100; end
            end
            5: begin
                e.an  = an_of(d);
                e.seg = 7'b0000100;
            end
            6, 7: begin
                if (d == 0) begin e.an = 4'b1110; e.seg = 7'b0000000; e.dp = 1'b0; end
                if (d == 1) begin e.an = 4'b1101; e.seg = 7'b0001111; end
                if (d == 3) begin e.an = 4'b0111; e.seg = 7'b0100100; end
            end
            default: ;
        endcase
        e.an_h  = e.an;
        e.seg_h = e.seg;
        e.dp_h  = e.dp;
        // The A on digit 1 is dark without hex glyphs, lit with them.
        if (f == 4 && d == 1) begin
            e.an_h  = 4'b1101;
            e.seg_h = 7'b0001000;
        end
        return e;
    endfunction

    task automatic tick(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
        bcd_in   = v;
        dp_in    = p;
        blank_in = b;
        load     = 1'b1;
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                mon_cyc++;
                checks++;
                if ({an, seg, dp, fd} === {mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd})
                    passed++;
                else
                    $display("FAIL scan_dec cyc%0d: got an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                             mon_cyc, an, seg, dp, fd, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
                checks++;
                if ({an_h, seg_h, dp_h, fd_h} === {mon_e.an_h, mon_e.seg_h, mon_e.dp_h, mon_e.fd})
                    passed++;
                else
                    $display("FAIL scan_hex cyc%0d: got an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                             mon_cyc, an_h, seg_h, dp_h, fd_h, mon_e.an_h, mon_e.seg_h, mon_e.dp_h, mon_e.fd);
                $display("cyc%0d an=%b seg=%b dp=%b fd=%b | hex an=%b seg=%b",
                         mon_cyc, an, seg, dp, fd, an_h, seg_h);
            end
        end
    end

    // Stimulus
    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;
        blank_in = 4'h0;

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) tick(RST);
        reset = 1'b0;

        // Main scan: k counts clocks since reset release
        for (int k = 1; k <= 120; k++) begin
            load = 1'b0;
            case (k)
                2:   do_load(16'h1234, 4'b0100, 4'b0000);
                20:  do_load(16'h0050, 4'b0000, 4'b0000);
                36:  do_load(16'h0000, 4'b0000, 4'b0000);
                52:  do_load(16'h00A0, 4'b0000, 4'b0000);
                80:  do_load(16'h9999, 4'b0000, 4'b0000);  // on the wrap edge
                84:  do_load(16'h1111, 4'b0000, 4'b0000);  // overwritten below
                86:  do_load(16'h5678, 4'b0001, 4'b0100);  // index at digit 1
                114: do_load(16'h4321, 4'b1111, 4'b0000);  // discarded by reset
                default: ;
            endcase
            tick(slot((k - 1) / 16, ((k - 1) / 4) % 4, (k % 16) == 0));
        end
        load = 1'b0;

        // Reset while the index is at digit 2 with a pending load
        reset = 1'b1;
        tick(RST);
        tick(RST);
        reset = 1'b0;

        // Two frames of zeros: shadow and pending both cleared
        for (int k = 1; k <= 32; k++) begin
            tick(slot(0, ((k - 1) / 4) % 4, (k % 16) == 0));
        end
        stim_done = 1'b1;
    end

    // Completion with a bounded drain wait
    initial begin
        int waited;
        waited = 0;
        while (!stim_done && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (!stim_done || q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, stimulus done=%0d, required 0 entries and done=1",
                     q.size(), stim_done);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
